// File: rtl/bufg_gt_ctrl_if.sv
// -----------------------------------------------------------------------------
// bufg_gt_ctrl_if
// Configuration request/response bundle between a requester and the
// BUFG_GT control sequencer.
//
// Signals
//   req      requester -> ctrl  one-cycle config request
//   req_div  requester -> ctrl  requested DIV code (divide ratio = code + 1)
//   req_en   requester -> ctrl  1 = buffer running after the sequence
//   ack      ctrl -> requester  one-cycle pulse, sequence complete
//   busy     ctrl -> requester  sequence in progress
//   drop     ctrl -> requester  one-cycle pulse, request discarded while busy
//
// Modports
//   master   requester side
//   slave    controller side
// -----------------------------------------------------------------------------
interface bufg_gt_ctrl_if;
    logic       req;
    logic [2:0] req_div;
    logic       req_en;
    logic       ack;
    logic       busy;
    logic       drop;

    modport master (
        output req,
        output req_div,
        output req_en,
        input  ack,
        input  busy,
        input  drop
    );

    modport slave (
        input  req,
        input  req_div,
        input  req_en,
        output ack,
        output busy,
        output drop
    );
endinterface

// File: rtl/bufg_gt_ctrl.sv
// -----------------------------------------------------------------------------
// bufg_gt_ctrl
// Control-side driver for one BUFG_GT clock buffer. A one-cycle config request
// (divide code + enable) is turned into a glitch-safe sequence:
//   gate CE -> hold CLR while DIV changes -> release CLR -> re-enable CE.
// Runs in the always-on control clock domain, never in the buffered clock.
//
// Parameters
//   SETTLE_CYCLES  cycles CLR is held asserted after the DIV update (1..255)
//   GAP_CYCLES     cycles between CLR release and CE assertion     (1..255)
//
// Ports
//   clk      in   control clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   cfg      slave modport of bufg_gt_ctrl_if (req/req_div/req_en in,
//            ack/busy/drop out)
//   ce       out  BUFG_GT CE
//   cemask   out  BUFG_GT CEMASK, tied low
//   clr      out  BUFG_GT CLR (active high)
//   clrmask  out  BUFG_GT CLRMASK, tied low
//   div      out  BUFG_GT DIV
//
// All outputs are registered. Each register is loaded from the value that
// belongs to the *next* state, so the outputs seen in a cycle always match
// the state held in that same cycle.
// -----------------------------------------------------------------------------
module bufg_gt_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bufg_gt_ctrl_if.slave      cfg,
    output logic               ce,
    output logic               cemask,
    output logic               clr,
    output logic               clrmask,
    output logic [2:0]         div
);

    // Counter reload values; a counter running from LOAD down to 0 spans
    // exactly LOAD+1 cycles in its state.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STOP    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nx_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nx_s;
    logic [2:0] cap_div_r;
    logic [2:0] cap_div_nx_s;
    logic       cap_en_r;
    logic       cap_en_nx_s;
    logic       ce_r;
    logic       ce_nx_s;
    logic       clr_r;
    logic       clr_nx_s;
    logic [2:0] div_r;
    logic [2:0] div_nx_s;
    logic       ack_r;
    logic       ack_nx_s;
    logic       busy_r;
    logic       busy_nx_s;
    logic       drop_r;
    logic       drop_nx_s;

    // Next-state and next-output logic for the config sequencer.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        cap_div_nx_s = cap_div_r;
        cap_en_nx_s  = cap_en_r;
        ce_nx_s      = ce_r;
        clr_nx_s     = clr_r;
        div_nx_s     = div_r;
        // A request arriving in any non-idle state (DONE included) is
        // discarded and reported one cycle later; capture is untouched.
        drop_nx_s    = cfg.req && (state_r != ST_IDLE);

        case (state_r)
            ST_IDLE: begin
                if (cfg.req) begin
                    cap_div_nx_s = cfg.req_div;
                    cap_en_nx_s  = cfg.req_en;
                    state_nx_s   = ST_STOP;
                    // Gate the buffer first; CLR/DIV keep their old values.
                    ce_nx_s      = 1'b0;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end

            ST_STOP: begin
                // CE has been low for a full cycle, safe to assert CLR and
                // move DIV in the same step.
                state_nx_s = ST_CLEAR;
                cnt_nx_s   = SETTLE_LOAD;
                ce_nx_s    = 1'b0;
                clr_nx_s   = 1'b1;
                div_nx_s   = cap_div_r;
            end

            ST_CLEAR: begin
                ce_nx_s  = 1'b0;
                clr_nx_s = 1'b1;
                if (cnt_r == 8'd0) begin
                    if (cap_en_r) begin
                        state_nx_s = ST_RELEASE;
                        cnt_nx_s   = GAP_LOAD;
                        clr_nx_s   = 1'b0;
                    end else begin
                        // Disable request: skip the release gap, the
                        // buffer stays in clear.
                        state_nx_s = ST_DONE;
                        ce_nx_s    = cap_en_r;
                        clr_nx_s   = ~cap_en_r;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 8'd1;
                end
            end

            ST_RELEASE: begin
                ce_nx_s  = 1'b0;
                clr_nx_s = 1'b0;
                if (cnt_r == 8'd0) begin
                    state_nx_s = ST_DONE;
                    ce_nx_s    = cap_en_r;
                    clr_nx_s   = ~cap_en_r;
                end else begin
                    cnt_nx_s = cnt_r - 8'd1;
                end
            end

            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end

            default: begin
                // Unreachable encoding: fall back to the safe cleared state.
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 8'd0;
                ce_nx_s    = 1'b0;
                clr_nx_s   = 1'b1;
            end
        endcase

        ack_nx_s  = (state_nx_s == ST_DONE);
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            cap_div_r <= 3'd0;
            cap_en_r  <= 1'b0;
            ce_r      <= 1'b0;
            clr_r     <= 1'b1;
            div_r     <= 3'd0;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            cap_div_r <= cap_div_nx_s;
            cap_en_r  <= cap_en_nx_s;
            ce_r      <= ce_nx_s;
            clr_r     <= clr_nx_s;
            div_r     <= div_nx_s;
            ack_r     <= ack_nx_s;
            busy_r    <= busy_nx_s;
            drop_r    <= drop_nx_s;
        end
    end

    assign ce       = ce_r;
    assign clr      = clr_r;
    assign div      = div_r;
    assign cemask   = 1'b0;
    assign clrmask  = 1'b0;
    assign cfg.ack  = ack_r;
    assign cfg.busy = busy_r;
    assign cfg.drop = drop_r;

endmodule

// File: tb/tb_bufg_gt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bufg_gt_ctrl
// Self-checking bench for bufg_gt_ctrl. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled there (or on the falling edge). Cycle n
// is the cycle after rising edge n; a request driven in cycle 0 is taken at
// edge 1, so STOP shows at n=1. Each accepted request pushes its expected
// completion onto a scoreboard that the ack monitor pops.
// -----------------------------------------------------------------------------
module tb_bufg_gt_ctrl;
    localparam int S = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce;
    logic       cemask;
    logic       clr;
    logic       clrmask;
    logic [2:0] div;

    bufg_gt_ctrl_if cfg_if ();

    bufg_gt_ctrl #(.SETTLE_CYCLES(S), .GAP_CYCLES(G)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_if),
        .ce      (ce),
        .cemask  (cemask),
        .clr     (clr),
        .clrmask (clrmask),
        .div     (div)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] div;
        logic       en;
        int         lat;
        int         start;
    } exp_t;

    exp_t sb_q[$];

    // Bench model of the buffer-side outputs between sequences.
    logic       m_ce;
    logic       m_clr;
    logic [2:0] m_div;

    logic [2:0] prev_div;
    logic       inv_armed = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every ack must match the oldest outstanding request.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst_n === 1'b1 && cfg_if.ack === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack cyc=%0d got ack=1 want no ack", cyc);
            end else begin
                e = sb_q.pop_front();
                if ({div, ce, clr} !== {e.div, e.en, ~e.en} || (cyc - e.start) != e.lat) begin
                    failures++;
                    $display("FAIL sb_ack got div=%0d ce=%b clr=%b lat=%0d want div=%0d ce=%b clr=%b lat=%0d",
                             div, ce, clr, cyc - e.start, e.div, e.en, ~e.en, e.lat);
                end
            end
        end
    end

    // Safety invariants on the buffer controls, every cycle.
    always @(negedge clk) begin
        checks++;
        if (ce === 1'b1 && clr === 1'b1) begin
            failures++;
            $display("FAIL inv_ce_clr cyc=%0d got ce=1 clr=1 want not both", cyc);
        end
        if (inv_armed && div !== prev_div) begin
            checks++;
            if (!(clr === 1'b1 && ce === 1'b0)) begin
                failures++;
                $display("FAIL inv_div_change cyc=%0d got div %0d->%0d with ce=%b clr=%b want ce=0 clr=1",
                         cyc, prev_div, div, ce, clr);
            end
        end
        prev_div  = div;
        inv_armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request in the current cycle and checks every output of
    // every cycle up to the first idle cycle after DONE (or up to stop_at).
    // Requests in cycles drop1/drop2 must be discarded.
    task automatic run_seq(input logic [2:0] d, input logic e, input int drop1,
                           input int drop2, input int stop_at, input string name);
        int         done_n;
        int         last;
        exp_t       x;
        logic [9:0] got_v;
        logic [9:0] want_v;
        logic       w_ce;
        logic       w_clr;
        logic [2:0] w_div;
        logic       w_drop;
        done_n  = e ? (S + G + 2) : (S + 2);
        last    = (stop_at > 0) ? stop_at : done_n + 1;
        x.div   = d;
        x.en    = e;
        x.lat   = done_n;
        x.start = cyc;
        sb_q.push_back(x);
        cfg_if.req     = 1'b1;
        cfg_if.req_div = d;
        cfg_if.req_en  = e;
        for (int n = 1; n <= last; n++) begin
            tick();
            // Inputs wander after accept; only drop-cycles raise req.
            cfg_if.req     = (n == drop1 || n == drop2) ? 1'b1 : 1'b0;
            cfg_if.req_div = ~d;
            cfg_if.req_en  = ~e;
            if (n == 1) begin
                w_ce = 1'b0; w_clr = m_clr; w_div = m_div;
            end else if (n <= S + 1) begin
                w_ce = 1'b0; w_clr = 1'b1; w_div = d;
            end else if (n < done_n) begin
                w_ce = 1'b0; w_clr = 1'b0; w_div = d;
            end else begin
                w_ce = e; w_clr = ~e; w_div = d;
            end
            w_drop = (drop1 > 0 && n == drop1 + 1) || (drop2 > 0 && n == drop2 + 1);
            got_v  = {cfg_if.ack, cfg_if.busy, cfg_if.drop, ce, clr, div, cemask, clrmask};
            want_v = {(n == done_n), (n <= done_n), w_drop, w_ce, w_clr, w_div, 1'b0, 1'b0};
            checks++;
            if (got_v !== want_v) begin
                failures++;
                $display("FAIL %s n=%0d got {ack,busy,drop,ce,clr,div,cm,clm}=%b want %b",
                         name, n, got_v, want_v);
            end
        end
        cfg_if.req = 1'b0;
        if (stop_at == 0) begin
            m_ce  = e;
            m_clr = ~e;
            m_div = d;
        end
    endtask

    task automatic test_reset();
        logic [9:0] got_v;
        cfg_if.req     = 1'b0;
        cfg_if.req_div = 3'd0;
        cfg_if.req_en  = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            got_v = {cfg_if.ack, cfg_if.busy, cfg_if.drop, ce, clr, div, cemask, clrmask};
            checks++;
            if (got_v !== 10'b00_0_0_1_000_00) begin
                failures++;
                $display("FAIL reset_idle i=%0d got %b want 0000100000", i, got_v);
            end
        end
        m_ce  = 1'b0;
        m_clr = 1'b1;
        m_div = 3'd0;
    endtask

    task automatic test_enable();
        run_seq(3'd3, 1'b1, 0, 0, 0, "enable");
    endtask

    task automatic test_disable();
        logic [9:0] got_v;
        run_seq(3'd5, 1'b0, 0, 0, 0, "disable");
        for (int i = 0; i < 5; i++) begin
            tick();
            got_v = {cfg_if.ack, cfg_if.busy, cfg_if.drop, ce, clr, div, cemask, clrmask};
            checks++;
            if (got_v !== 10'b00_0_0_1_101_00) begin
                failures++;
                $display("FAIL disable_hold i=%0d got %b want 0000110100", i, got_v);
            end
        end
    endtask

    task automatic test_drop();
        run_seq(3'd2, 1'b1, 4, S + G + 2, 0, "drop");
    endtask

    task automatic test_back_to_back();
        run_seq(3'd1, 1'b1, 0, 0, 0, "b2b_first");
        run_seq(3'd1, 1'b1, 0, 0, 0, "b2b_same_div");
    endtask

    task automatic test_reset_mid();
        logic [9:0] got_v;
        run_seq(3'd6, 1'b1, 0, 0, 11, "reset_mid_pre");
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        got_v = {cfg_if.ack, cfg_if.busy, cfg_if.drop, ce, clr, div, cemask, clrmask};
        checks++;
        if (got_v !== 10'b00_0_0_1_000_00) begin
            failures++;
            $display("FAIL reset_mid_now got %b want 0000100000", got_v);
        end
        m_ce  = 1'b0;
        m_clr = 1'b1;
        m_div = 3'd0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            got_v = {cfg_if.ack, cfg_if.busy, cfg_if.drop, ce, clr, div, cemask, clrmask};
            checks++;
            if (got_v !== 10'b00_0_0_1_000_00) begin
                failures++;
                $display("FAIL reset_mid_after i=%0d got %b want 0000100000", i, got_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_disable();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d outstanding want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
